// File: rtl/shape_cmd_scheduler.sv
// shape_cmd_scheduler: round-robin sharing of the shape processor ctrl write/read port.
// Optional feature macro: SHAPE_SCHED_READBACK_EN adds the READ state and ctrl readback into rsp_data.
module shape_cmd_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_error,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic                  write,
    output logic [31:0]           write_data,
    output logic                  read,
    input  logic [31:0]           read_data,
    input  logic                  error
);

    typedef enum logic [2:0] {IDLE, WRITE, CHECK, READ, RESP} state_t;

    state_t          state;
    state_t          next_state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [31:0]     word_q;
    logic            err_q;

    // Index base+offset modulo NUM_REQ; offset is always below NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // req_ready is qualified by rst_n so every output is low while reset is held.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        write      = 1'b0;
        read       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = rst_n;
                    next_state           = WRITE;
                end
            end
            WRITE: begin
                write      = 1'b1;
                next_state = CHECK;
            end
            CHECK: begin
`ifdef SHAPE_SCHED_READBACK_EN
                next_state = READ;
`else
                next_state = RESP;
`endif
            end
            READ: begin
`ifdef SHAPE_SCHED_READBACK_EN
                read       = 1'b1;
                next_state = RESP;
`else
                next_state = IDLE;
`endif
            end
            RESP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            word_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && grant_found) begin
                id_q   <= grant_idx;
                word_q <= req_data[32*grant_idx +: 32];
            end
            if (state == CHECK) err_q <= error;
            if (state == RESP && rsp_ready) rr_ptr <= wrap_idx(id_q, 1);
        end
    end

`ifdef SHAPE_SCHED_READBACK_EN
    logic [31:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              data_q <= '0;
        else if (state == READ)  data_q <= read_data;
    end

    assign rsp_data = data_q;
`else
    logic unused_read_data;

    assign unused_read_data = ^read_data;
    assign rsp_data         = '0;
`endif

    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_error  = err_q;
    assign write_data = (state == WRITE) ? word_q : '0;

endmodule

// File: doc/shape_cmd_scheduler.md
Name: shape_cmd_scheduler

Overview:
Shares the shape processor's control register write/read port between NUM_REQ independent requesters. Each request carries one 32-bit ctrl word. The block arbitrates round-robin, issues the write, captures the processor's error verdict, optionally reads the ctrl register back, and returns a single tagged response. It sits between the requester fabric and the shape processor's write/read/error interface and owns that interface exclusively.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8
ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_data  input  NUM_REQ*32  per-requester ctrl word; requester i uses bits [32*i+31:32*i]
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  ID_W  index of the requester being answered
rsp_error  output  1  processor rejected the write
rsp_data  output  32  ctrl register value read back after the write
busy  output  1  high in every state other than IDLE
write  output  1  ctrl write strobe to the processor
write_data  output  32  ctrl write data
read  output  1  ctrl read strobe to the processor
read_data  input  32  ctrl read data; valid in the same cycle as read
error  input  1  processor pulses this one cycle after a rejected write

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, RR pointer=0. All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_error, rsp_data, write, write_data, read and busy.
- States: IDLE, WRITE, CHECK, READ, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid high, searching from the RR pointer upward with wrap-around.
  - req_ready is high for the granted bit only, combinationally, in IDLE only.
  - On a grant, latch req_data and the requester index, then go to WRITE.
  - If no requester is valid, stay in IDLE.
- WRITE: write=1 and write_data=latched word for exactly 1 cycle, then go to CHECK.
- CHECK: sample error into rsp_error. Go to READ when the readback feature is compiled in; otherwise go to RESP.
- READ: read=1 for exactly 1 cycle, capture read_data into rsp_data, then go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_error and rsp_data held stable until rsp_ready is high.
  - On rsp_valid && rsp_ready: go to IDLE and set the RR pointer to (granted index + 1) mod NUM_REQ.
- Latency with the request accepted in cycle T:
  - write in T+1, error sampled in T+2, read in T+3, rsp_valid in T+4.
  - Without readback, rsp_valid is in T+3.
- Invariants:
  - write and read are never high in the same cycle.
  - Only one request is in flight at a time.
  - A requester's req_valid dropping after acceptance has no effect.
  - The error input is ignored outside CHECK.
- The scheduler never inspects or decodes the SHAPE/OPERATION fields. Legality, including KEEP_SHAPE/KEEP_OPERATION handling, is the processor's job.
- Simultaneous requests: the RR order guarantees no requester waits more than NUM_REQ-1 grants.
- rsp_ready held low: the FSM stalls in RESP indefinitely and no new grant is issued.
- rsp_ready high on the first RESP cycle: single-cycle response, and IDLE is re-entered the next cycle. A new grant is possible in that IDLE cycle.
- Reset mid-operation: the FSM aborts immediately and no response is issued. The requester must re-send.

Optional Feature:
SHAPE_SCHED_READBACK_EN
- Defined: READ state present; rsp_data = ctrl register value after the write; response latency is 4 cycles.
- Undefined: READ state removed; read tied to 0; rsp_data tied to 0; response latency is 3 cycles.

Test Plan:
- Single request: requester 0 sends 0x0000_0102, the processor accepts it, rsp_ready=1 -> write at T+1 with write_data=0x0000_0102; rsp_valid at T+4 with rsp_id=0, rsp_error=0, rsp_data=0x0000_0102 (T+3 and rsp_data=0 without readback).
- Rejected write: the processor pulses error in CHECK and read_data=0x0000_0201 (the old value) -> rsp_error=1, rsp_data=0x0000_0201.
- Fairness: NUM_REQ=4, all four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with exactly one req_ready bit per grant.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_id/rsp_error/rsp_data held stable, busy=1, no req_ready, no write.
- Reset mid-op: rst_n asserted in CHECK -> all outputs 0 asynchronously; after release, the next grant goes to requester 0.
- Spurious error: error pulsed while in IDLE or READ -> the subsequent response has rsp_error=0.
